// File: rtl/bidir_pkg.sv
// -----------------------------------------------------------------------------
// bidir_pkg
//   Shared definitions for the bidirectional bus arbiter.
//   - state_t : arbiter FSM encoding (also exported on the debug port)
//   - HOLD_W  : width of the ownership hold counter
//   - TURN_W  : width of the turnaround (dead gap) counter
//   - sat_inc : saturating increment for the hold counter
// -----------------------------------------------------------------------------
package bidir_pkg;

    localparam int HOLD_W = 8;
    localparam int TURN_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN1 = 2'd1,
        S_OWN2 = 2'd2,
        S_TURN = 2'd3
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

    // The hold counter must never wrap: a wrapped count could match the
    // preemption threshold a second time during one long ownership.
    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
        return (v == HOLD_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bidir_bus_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
//   Combinational 2-way round-robin chooser.
//   Ports:
//     req1, req2 : pending requests
//     last       : previous owner (0 = requester 1, 1 = requester 2)
//     pick       : chosen requester (0 = requester 1, 1 = requester 2);
//                  only meaningful when req1 | req2
//   A lone request always wins, whatever last says; a tie goes to the
//   requester that did not own the line most recently.
// -----------------------------------------------------------------------------
module rr_pick2 (
    input  logic req1,
    input  logic req2,
    input  logic last,
    output logic pick
);

    always_comb begin
        pick = 1'b0;
        if (req1 && req2) begin
            pick = ~last;
        end else begin
            pick = req2;
        end
    end

endmodule

// File: rtl/bidir_bus_arbiter.sv
// -----------------------------------------------------------------------------
// bidir_bus_arbiter
//   Arbitrates ownership of a shared bidirectional data line between two
//   requesters and drives the tristate enables of the bidir wrapper. The two
//   enables are never high together, a dead gap of TURN_CYC cycles separates
//   consecutive owners, and an owner is forced off after MAX_HOLD cycles if the
//   other side is waiting at that point (MAX_HOLD = 0 disables this).
//
//   Parameters:
//     TURN_CYC  : dead cycles between owners, 1..15
//     MAX_HOLD  : owned cycles before preemption, 0..255 (0 = never preempt)
//   Ports:
//     clk        : arbiter clock (clk_2mhz)
//     rst_n      : asynchronous active-low reset
//     locked     : clock generator lock; nothing is granted while low and a
//                  current owner is released when it drops
//     req1/req2  : request to drive the line
//     gnt1/gnt2  : requester owns the line
//     data_en1/2 : tristate enables, identical to gnt1/gnt2
//     busy       : arbiter is not idle (owning or in turnaround)
//     preempt    : one-cycle pulse in the first turnaround cycle after an
//                  owner was forced off by MAX_HOLD
//     dbg_state  : current FSM state (bidir_pkg::state_t encoding)
//
//   Handshake: reqx is raised and held until gntx is seen; gntx rises one
//   cycle after the request is accepted and stays high for as long as reqx
//   stays high (and locked stays high and no preemption happens). Dropping
//   reqx before the grant simply withdraws the request; dropping it while
//   owning releases the line on the next edge.
//
//   All outputs are registered: each is computed from the next-state logic
//   and loaded on the same edge as the state register.
// -----------------------------------------------------------------------------
module bidir_bus_arbiter
    import bidir_pkg::*;
#(
    parameter int TURN_CYC = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       req1,
    input  logic       req2,
    output logic       gnt1,
    output logic       gnt2,
    output logic       data_en1,
    output logic       data_en2,
    output logic       busy,
    output logic       preempt,
    output logic [1:0] dbg_state
);

    // Counter reload / threshold values, sized to their counters.
    localparam logic [TURN_W-1:0] TURN_LOAD  = TURN_W'(TURN_CYC - 1);
    localparam logic              PREEMPT_EN = (MAX_HOLD > 0);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

    state_t              state;
    state_t              state_nx;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_nx;
    logic [TURN_W-1:0]   turn_cnt;
    logic [TURN_W-1:0]   turn_nx;
    // 0 = requester 1 owned last, 1 = requester 2 owned last.
    logic                last;
    logic                last_nx;
    logic                preempt_nx;

    logic                pick;
    logic                any_req;
    logic                own_req;
    logic                other_req;
    logic                hold_hit;
    state_t              grant_state;

    rr_pick2 u_rr_pick2 (
        .req1 (req1),
        .req2 (req2),
        .last (last),
        .pick (pick)
    );

    assign dbg_state = state;

    // -------------------------------------------------------------------------
    // Next-state and counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx    = state;
        hold_nx     = hold_cnt;
        turn_nx     = turn_cnt;
        last_nx     = last;
        preempt_nx  = 1'b0;

        any_req     = req1 | req2;
        grant_state = pick ? S_OWN2 : S_OWN1;

        // Request of the current owner and of the side that is waiting.
        own_req     = (state == S_OWN2) ? req2 : req1;
        other_req   = (state == S_OWN2) ? req1 : req2;

        // Preemption fires only on the exact cycle the hold count reaches its
        // limit while the other side is requesting; a request that arrives
        // later does not cut the ownership short.
        hold_hit    = PREEMPT_EN && (hold_cnt == HOLD_LIMIT) && other_req;

        case (state)
            S_IDLE: begin
                if (locked && any_req) begin
                    state_nx = grant_state;
                    hold_nx  = '0;
                end
            end

            S_OWN1, S_OWN2: begin
                if (!own_req || !locked || hold_hit) begin
                    state_nx   = S_TURN;
                    turn_nx    = TURN_LOAD;
                    last_nx    = (state == S_OWN2);
                    // A release or a lock loss takes priority: only flag the
                    // exit as a preemption when the owner still wanted the line.
                    preempt_nx = own_req && locked;
                end else begin
                    hold_nx = sat_inc(hold_cnt);
                end
            end

            S_TURN: begin
                if (turn_cnt == '0) begin
                    if (locked && any_req) begin
                        state_nx = grant_state;
                        hold_nx  = '0;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    turn_nx = turn_cnt - 1'b1;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counters and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            turn_cnt <= '0;
            last     <= 1'b1;
            gnt1     <= 1'b0;
            gnt2     <= 1'b0;
            data_en1 <= 1'b0;
            data_en2 <= 1'b0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
            turn_cnt <= turn_nx;
            last     <= last_nx;
            gnt1     <= (state_nx == S_OWN1);
            gnt2     <= (state_nx == S_OWN2);
            data_en1 <= (state_nx == S_OWN1);
            data_en2 <= (state_nx == S_OWN2);
            busy     <= (state_nx != S_IDLE);
            preempt  <= preempt_nx;
        end
    end

endmodule

// File: tb/tb_bidir_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bidir_bus_arbiter
//   Three arbiters with different (TURN_CYC, MAX_HOLD) share the same stimulus.
//   A behavioural model per instance (owner / remaining gap / hold count)
//   predicts every output each cycle; directed sequences add targeted checks
//   on instance 0 and a long random run covers the rest.
// -----------------------------------------------------------------------------
module tb_bidir_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic       locked;
    logic       req1;
    logic       req2;

    logic [2:0] g1, g2, e1, e2, bz, pr;
    logic [1:0] dbg0, dbg1, dbg2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    string phase = "init";

    // Per-instance configuration.
    int tc [3] = '{2, 1, 3};
    int mh [3] = '{8, 3, 0};

    // Reference model state: owner 0 = none, 1 or 2; gap = dead cycles left.
    int m_owner [3];
    int m_gap   [3];
    int m_hold  [3];
    int m_last  [3];
    int m_pre   [3];

    // Output-based gap tracking.
    int zero_run [3];
    bit seen_en  [3];
    bit prev_en  [3];
    logic [1:0] prev_pair [3];

    // -------------------------------------------------------------------------
    // Clock
    // -------------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // DUTs
    // -------------------------------------------------------------------------
    bidir_bus_arbiter #(.TURN_CYC(2), .MAX_HOLD(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .locked(locked), .req1(req1), .req2(req2),
        .gnt1(g1[0]), .gnt2(g2[0]), .data_en1(e1[0]), .data_en2(e2[0]),
        .busy(bz[0]), .preempt(pr[0]), .dbg_state(dbg0)
    );

    bidir_bus_arbiter #(.TURN_CYC(1), .MAX_HOLD(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .locked(locked), .req1(req1), .req2(req2),
        .gnt1(g1[1]), .gnt2(g2[1]), .data_en1(e1[1]), .data_en2(e2[1]),
        .busy(bz[1]), .preempt(pr[1]), .dbg_state(dbg1)
    );

    bidir_bus_arbiter #(.TURN_CYC(3), .MAX_HOLD(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .locked(locked), .req1(req1), .req2(req2),
        .gnt1(g1[2]), .gnt2(g2[2]), .data_en1(e1[2]), .data_en2(e2[2]),
        .busy(bz[2]), .preempt(pr[2]), .dbg_state(dbg2)
    );

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [%s cyc %0d] got=%0h exp=%0h", tag, phase, cyc, got, exp);
        end
    endtask

    function automatic logic [5:0] observed(input int i);
        return {g1[i], g2[i], e1[i], e2[i], bz[i], pr[i]};
    endfunction

    function automatic logic [5:0] expected(input int i);
        logic o1, o2, b;
        o1 = (m_owner[i] == 1);
        o2 = (m_owner[i] == 2);
        b  = (m_owner[i] != 0) || (m_gap[i] > 0);
        return {o1, o2, o1, o2, b, (m_pre[i] != 0)};
    endfunction

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_owner[i]   = 0;
            m_gap[i]     = 0;
            m_hold[i]    = 0;
            m_last[i]    = 2;
            m_pre[i]     = 0;
            zero_run[i]  = 0;
            seen_en[i]   = 1'b0;
            prev_en[i]   = 1'b0;
            prev_pair[i] = 2'b00;
        end
    endtask

    task automatic model_grant(input int i, input bit r1, input bit r2, input bit lk);
        if (lk && (r1 || r2)) begin
            if (r1 && r2) m_owner[i] = (m_last[i] == 1) ? 2 : 1;
            else          m_owner[i] = r1 ? 1 : 2;
            m_hold[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit r1, input bit r2, input bit lk);
        bit mine, other;
        m_pre[i] = 0;
        if (m_owner[i] != 0) begin
            mine  = (m_owner[i] == 1) ? r1 : r2;
            other = (m_owner[i] == 1) ? r2 : r1;
            if (!mine || !lk || (mh[i] > 0 && m_hold[i] == mh[i] - 1 && other)) begin
                if (mine && lk) m_pre[i] = 1;
                m_last[i]  = m_owner[i];
                m_owner[i] = 0;
                m_gap[i]   = tc[i];
            end else begin
                m_hold[i] = (m_hold[i] < 255) ? m_hold[i] + 1 : 255;
            end
        end else if (m_gap[i] > 0) begin
            if (m_gap[i] == 1) begin
                m_gap[i] = 0;
                model_grant(i, r1, r2, lk);
            end else begin
                m_gap[i]--;
            end
        end else begin
            model_grant(i, r1, r2, lk);
        end
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    // One clock: model advances on the edge, outputs compared 1 ns later.
    task automatic tick();
        bit en_now;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, req1, req2, locked);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("outputs_%0d", i), observed(i), expected(i));
            check($sformatf("mutex_%0d", i), e1[i] & e2[i], 1'b0);
            en_now = e1[i] | e2[i];
            if (en_now && !prev_en[i] && seen_en[i])
                check($sformatf("gap_%0d", i), (zero_run[i] >= tc[i]), 1'b1);
            if (en_now && prev_en[i])
                check($sformatf("swap_%0d", i), {e1[i], e2[i]}, prev_pair[i]);
            if (en_now) begin
                seen_en[i]  = 1'b1;
                zero_run[i] = 0;
            end else begin
                zero_run[i]++;
            end
            prev_en[i]   = en_now;
            prev_pair[i] = {e1[i], e2[i]};
        end
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear
    // without waiting for an edge.
    task automatic async_reset(input bit r1, input bit r2, input bit lk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_out_%0d", i), observed(i), 6'b0);
        check("reset_state", dbg0, 2'd0);
        req1   = r1;
        req2   = r2;
        locked = lk;
        #2;
        rst_n = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int n_g1, n_g2, n_pre, n_turn, n_dead, pre_at, first_g2;

        rst_n  = 1'b1;
        locked = 1'b0;
        req1   = 1'b0;
        req2   = 1'b0;
        model_reset();
        #1;
        async_reset(1'b0, 1'b0, 1'b0);

        // Single requester holds for five cycles.
        phase  = "single";
        locked = 1'b1;
        req1   = 1'b1;
        n_g1 = 0; n_g2 = 0; n_turn = 0;
        repeat (5) begin
            tick();
            n_g1 += int'(g1[0]);
            n_g2 += int'(g2[0]);
        end
        check("single_gnt1_cycles", n_g1, 5);
        req1 = 1'b0;
        repeat (2) begin
            tick();
            if (bz[0] && !g1[0] && !g2[0]) n_turn++;
            n_g2 += int'(g2[0]);
        end
        check("single_turn_cycles", n_turn, 2);
        tick();
        check("single_idle_busy", bz[0], 1'b0);
        check("single_idle_state", dbg0, 2'd0);
        check("single_gnt2_never", n_g2, 0);

        // Tie after reset, then preemption at MAX_HOLD.
        phase = "tie";
        async_reset(1'b0, 1'b0, 1'b1);
        req1 = 1'b1;
        req2 = 1'b1;
        n_g1 = 0; n_pre = 0; pre_at = 0; first_g2 = 0; n_dead = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) check("tie_first_gnt1", g1[0], 1'b1);
            if (g1[0]) n_g1++;
            if (pr[0]) begin n_pre++; pre_at = c; end
            if (g2[0] && first_g2 == 0) first_g2 = c;
            if (!e1[0] && !e2[0]) n_dead++;
        end
        check("tie_gnt1_cycles", n_g1, 8);
        check("tie_preempt_count", n_pre, 1);
        check("tie_preempt_cycle", pre_at, 9);
        check("tie_first_gnt2", first_g2, 11);
        check("tie_dead_cycles", n_dead, 2);
        req1 = 1'b0;
        req2 = 1'b0;
        repeat (5) tick();

        // Lone requester is never preempted.
        phase = "hold";
        req1  = 1'b1;
        n_g1 = 0; n_pre = 0;
        repeat (25) begin
            tick();
            n_g1  += int'(g1[0]);
            n_pre += int'(pr[0]);
        end
        check("hold_gnt1_cycles", n_g1, 25);
        check("hold_no_preempt", n_pre, 0);
        req1 = 1'b0;
        repeat (5) tick();

        // Lock gating and lock loss while owning.
        phase  = "lock";
        locked = 1'b0;
        req2   = 1'b1;
        n_g2 = 0;
        repeat (3) begin
            tick();
            n_g2 += int'(g2[0]);
        end
        check("lock_no_grant", n_g2, 0);
        locked = 1'b1;
        tick();
        check("lock_gnt2", {g2[0], e2[0]}, 2'b11);
        repeat (2) tick();
        locked = 1'b0;
        tick();
        check("lock_drop_turn", {e2[0], bz[0]}, 2'b01);
        tick();
        check("lock_turn2_busy", bz[0], 1'b1);
        tick();
        check("lock_idle", {g2[0], bz[0]}, 2'b00);

        // Reset in the middle of an ownership, tie on release.
        phase  = "midreset";
        locked = 1'b1;
        repeat (2) tick();
        check("mid_own2", g2[0], 1'b1);
        async_reset(1'b1, 1'b1, 1'b1);
        tick();
        check("mid_tie_gnt1", {g1[0], g2[0]}, 2'b10);

        // Random run.
        phase = "random";
        async_reset(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 10000; n++) begin
            locked = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 7) == 0) req1 = ~req1;
            if ($urandom_range(0, 7) == 0) req2 = ~req2;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound on the whole run.
    initial begin
        #1_000_000;
        $display("FAIL timeout [%s cyc %0d] got=running exp=finished", phase, cyc);
        $fatal(1, "timeout");
    end

endmodule
